// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// shifts them out MSB-first, one bit per clock, with zero-gap back-to-back reload.
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("bit_serializer: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;
    logic             accept;

    // Ready depends on state only, so upstream never sees a valid->ready loop.
    assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign data_ready = (state == IDLE) || last_bit;
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                shreg   <= data_in;
                bit_cnt <= '0;
                state   <= SHIFT;
            end
        end else begin
            if (!last_bit) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (accept) begin
                // Reload on the LSB edge keeps the stream gap-free.
                shreg   <= data_in;
                bit_cnt <= '0;
            end else begin
                state   <= IDLE;
            end
        end
    end

    assign serial_out   = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;
    assign serial_valid = (state == SHIFT);
    assign word_done    = last_bit;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: two instances share stimulus, differing
// only in IDLE_BIT, so idle-level behaviour is checked for both settings.
module tb_bit_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;

    logic ready0, sout0, sval0, done0;
    logic ready1, sout1, sval1, done1;

    int passed;
    int total;

    bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut0 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready0), .serial_out(sout0), .serial_valid(sval0), .word_done(done0)
    );

    bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b1)) dut1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready1), .serial_out(sout1), .serial_valid(sval1), .word_done(done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data_valid = 1'b0;
        data_in = '0;
        #2;
        reset = 1'b1;
        #1;
        total++; if (sout0 !== 1'b0) $display("FAIL reset_sout0 got=%b exp=0", sout0); else passed++;
        total++; if (sout1 !== 1'b1) $display("FAIL reset_sout1 got=%b exp=1", sout1); else passed++;
        total++; if (sval0 !== 1'b0) $display("FAIL reset_sval got=%b exp=0", sval0); else passed++;
        total++; if (done0 !== 1'b0) $display("FAIL reset_done got=%b exp=0", done0); else passed++;
        total++; if (ready0 !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready0); else passed++;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        total++; if (sval0 !== 1'b0 || ready0 !== 1'b1) $display("FAIL reset_release sval=%b ready=%b exp sval=0 ready=1", sval0, ready0); else passed++;
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'h0B;
        data_in = w;
        data_valid = 1'b1;
        next_cycle();
        data_valid = 1'b0;
        data_in = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            total++; if (sout0 !== w[7-i]) $display("FAIL single_bit%0d got=%b exp=%b", i, sout0, w[7-i]); else passed++;
            total++; if (sval0 !== 1'b1) $display("FAIL single_valid%0d got=%b exp=1", i, sval0); else passed++;
            total++; if (done0 !== (i == 7)) $display("FAIL single_done%0d got=%b exp=%b", i, done0, (i == 7)); else passed++;
            if (i < 7) next_cycle();
        end
        next_cycle();
        total++; if (sval0 !== 1'b0 || sout0 !== 1'b0 || done0 !== 1'b0) $display("FAIL single_idle sval=%b sout=%b done=%b exp 0,0,0", sval0, sout0, done0); else passed++;
        total++; if (sout1 !== 1'b1) $display("FAIL single_idle1 got=%b exp=1", sout1); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        int dones;
        stream = 16'b1011_0101_0110_1101;
        dones = 0;
        data_in = 8'hB5;
        data_valid = 1'b1;
        next_cycle();
        data_in = 8'h6D;
        for (int i = 0; i < 16; i++) begin
            total++; if (sout0 !== stream[15-i]) $display("FAIL b2b_bit%0d got=%b exp=%b", i, sout0, stream[15-i]); else passed++;
            total++; if (sval0 !== 1'b1) $display("FAIL b2b_valid%0d got=%b exp=1", i, sval0); else passed++;
            total++; if (ready0 !== (i == 7 || i == 15)) $display("FAIL b2b_ready%0d got=%b exp=%b", i, ready0, (i == 7 || i == 15)); else passed++;
            if (done0 === 1'b1) dones++;
            if (i == 15) data_valid = 1'b0;
            else next_cycle();
        end
        total++; if (dones != 2) $display("FAIL b2b_done_count got=%0d exp=2", dones); else passed++;
        next_cycle();
        total++; if (sval0 !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", sval0); else passed++;
    endtask

    task automatic test_backpressure();
        data_in = 8'h00;
        data_valid = 1'b1;
        next_cycle();
        data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) data_valid = 1'b0;
            total++; if (sout0 !== (i >= 8)) $display("FAIL bp_bit%0d got=%b exp=%b", i, sout0, (i >= 8)); else passed++;
            total++; if (sval0 !== 1'b1) $display("FAIL bp_valid%0d got=%b exp=1", i, sval0); else passed++;
            if (i >= 1 && i <= 6) begin
                total++; if (ready0 !== 1'b0) $display("FAIL bp_ready%0d got=%b exp=0", i, ready0); else passed++;
            end
            if (i == 1) begin
                data_in = 8'hFF;
                data_valid = 1'b1;
            end
            next_cycle();
        end
        total++; if (sval0 !== 1'b0) $display("FAIL bp_idle got=%b exp=0", sval0); else passed++;
    endtask

    task automatic test_gap_idle();
        data_in = 8'h80;
        data_valid = 1'b1;
        next_cycle();
        data_valid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            logic exp_sv, exp_b0, exp_b1;
            if (i < 8) begin
                exp_sv = 1'b1; exp_b0 = (i == 0); exp_b1 = (i == 0);
            end else if (i <= 12) begin
                exp_sv = 1'b0; exp_b0 = 1'b0; exp_b1 = 1'b1;
            end else begin
                exp_sv = 1'b1; exp_b0 = (i == 20); exp_b1 = (i == 20);
            end
            total++; if (sout0 !== exp_b0) $display("FAIL gap_bit0_%0d got=%b exp=%b", i, sout0, exp_b0); else passed++;
            total++; if (sout1 !== exp_b1) $display("FAIL gap_bit1_%0d got=%b exp=%b", i, sout1, exp_b1); else passed++;
            total++; if (sval0 !== exp_sv || sval1 !== exp_sv) $display("FAIL gap_valid%0d got=%b/%b exp=%b", i, sval0, sval1, exp_sv); else passed++;
            if (i == 12) begin
                data_in = 8'h01;
                data_valid = 1'b1;
            end
            if (i < 20) next_cycle();
            if (i == 12) data_valid = 1'b0;
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'hA5;
        data_in = w;
        data_valid = 1'b1;
        next_cycle();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (sout0 !== w[7-i]) $display("FAIL rmw_bit%0d got=%b exp=%b", i, sout0, w[7-i]); else passed++;
            if (i < 2) next_cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        total++; if (sval0 !== 1'b0 || done0 !== 1'b0 || ready0 !== 1'b1 || sout0 !== 1'b0) $display("FAIL rmw_async sval=%b done=%b ready=%b sout=%b exp 0,0,1,0", sval0, done0, ready0, sout0); else passed++;
        repeat (2) begin
            next_cycle();
            total++; if (done0 !== 1'b0 || sval0 !== 1'b0) $display("FAIL rmw_held done=%b sval=%b exp 0,0", done0, sval0); else passed++;
        end
        reset = 1'b0;
        next_cycle();
        total++; if (done0 !== 1'b0 || sval0 !== 1'b0) $display("FAIL rmw_after done=%b sval=%b exp 0,0", done0, sval0); else passed++;
        w = 8'h3C;
        data_in = w;
        data_valid = 1'b1;
        next_cycle();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (sout0 !== w[7-i]) $display("FAIL rmw_new_bit%0d got=%b exp=%b", i, sout0, w[7-i]); else passed++;
            total++; if (done0 !== (i == 7)) $display("FAIL rmw_new_done%0d got=%b exp=%b", i, done0, (i == 7)); else passed++;
            next_cycle();
        end
        total++; if (sval0 !== 1'b0) $display("FAIL rmw_final_idle got=%b exp=0", sval0); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_gap_idle();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
